// File: rtl/vec_pipe_if.sv
// Handshake and bundle signals around one vector pipeline stage.
// The master drives the inputs and consumes the held bundle; the slave is the stage.
interface vec_pipe_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int IMM_W  = 32,
  parameter int CTRL_W = 24,
  parameter int TAG_W  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [LANES-1:0]        lane_en_in;
  logic [LANES*DATA_W-1:0] rd1_in;
  logic [LANES*DATA_W-1:0] rd2_in;
  logic [IMM_W-1:0]        imm_in;
  logic [CTRL_W-1:0]       ctrl_in;
  logic [TAG_W-1:0]        tag_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        lane_en_out;
  logic [LANES*DATA_W-1:0] rd1_out;
  logic [LANES*DATA_W-1:0] rd2_out;
  logic [IMM_W-1:0]        imm_out;
  logic [CTRL_W-1:0]       ctrl_out;
  logic [TAG_W-1:0]        tag_out;

  modport master (
    output in_valid, flush, lane_en_in, rd1_in, rd2_in,
    output imm_in, ctrl_in, tag_in, out_ready,
    input  in_ready, out_valid, lane_en_out, rd1_out,
    input  rd2_out, imm_out, ctrl_out, tag_out
  );

  modport slave (
    input  in_valid, flush, lane_en_in, rd1_in, rd2_in,
    input  imm_in, ctrl_in, tag_in, out_ready,
    output in_ready, out_valid, lane_en_out, rd1_out,
    output rd2_out, imm_out, ctrl_out, tag_out
  );
endinterface

// File: rtl/vec_pipe_stage.sv
// Elastic vector pipeline register with a two-entry skid buffer,
// synchronous flush and per-lane capture masking.
module vec_pipe_stage #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int IMM_W  = 32,
  parameter int CTRL_W = 24,
  parameter int TAG_W  = 4
) (
  input logic     CLK,
  input logic     RST_N,
  vec_pipe_if.slave bus
);
  localparam int VW = LANES * DATA_W;

  typedef struct packed {
    logic [LANES-1:0]  en;
    logic [VW-1:0]     rd1;
    logic [VW-1:0]     rd2;
    logic [IMM_W-1:0]  imm;
    logic [CTRL_W-1:0] ctrl;
    logic [TAG_W-1:0]  tag;
  } bnd_t;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } state_t;

  state_t state, nxt;
  bnd_t   m, s, cap;
  logic   rdy;
  logic   in_acc;
  logic   ld_m_in;
  logic   ld_m_s;
  logic   ld_s;

  always_comb begin
    cap      = '0;
    cap.en   = bus.lane_en_in;
    cap.imm  = bus.imm_in;
    cap.ctrl = bus.ctrl_in;
    cap.tag  = bus.tag_in;
    for (int i = 0; i < LANES; i++) begin
      if (bus.lane_en_in[i]) begin
        cap.rd1[i*DATA_W +: DATA_W] = bus.rd1_in[i*DATA_W +: DATA_W];
        cap.rd2[i*DATA_W +: DATA_W] = bus.rd2_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_acc = bus.in_valid & rdy;

  always_comb begin
    nxt     = state;
    ld_m_in = 1'b0;
    ld_m_s  = 1'b0;
    ld_s    = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_acc) begin
          ld_m_in = 1'b1;
          nxt     = FULL;
        end
      end
      FULL: begin
        if (in_acc && bus.out_ready) begin
          ld_m_in = 1'b1;
        end else if (in_acc) begin
          ld_s = 1'b1;
          nxt  = SKID;
        end else if (bus.out_ready) begin
          nxt = EMPTY;
        end
      end
      SKID: begin
        if (bus.out_ready) begin
          ld_m_s = 1'b1;
          nxt    = FULL;
        end
      end
      default: nxt = EMPTY;
    endcase
  end

  // Flush keeps M's payload but kills ctrl so write enables drop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= EMPTY;
      rdy   <= 1'b1;
      m     <= '0;
      s     <= '0;
    end else if (bus.flush) begin
      state  <= EMPTY;
      rdy    <= 1'b1;
      m.ctrl <= '0;
    end else begin
      state <= nxt;
      rdy   <= (nxt != SKID);
      if (ld_m_in) begin
        m <= cap;
      end else if (ld_m_s) begin
        m <= s;
      end
      if (ld_s) begin
        s <= cap;
      end
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = (state != EMPTY);
  assign bus.lane_en_out = m.en;
  assign bus.rd1_out     = m.rd1;
  assign bus.rd2_out     = m.rd2;
  assign bus.imm_out     = m.imm;
  assign bus.ctrl_out    = m.ctrl;
  assign bus.tag_out     = m.tag;
endmodule
